// File: rtl/h264_pkg.sv
// Shared types and constants for the luma intra 4x4 sequencing logic.
// Holds the scheduler state encoding and the frame-size helpers.
package h264_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;

    localparam int          BLK_PER_MB    = 16;
    localparam logic [11:0] MAX_FRAME_DIM = 12'd1024;

    // Macroblocks needed to cover a pixel dimension; partial MBs round up.
    function automatic logic [6:0] mbs_for_dim(input logic [11:0] dim);
        return 7'(({1'b0, dim} + 13'd15) >> 4);
    endfunction

    function automatic logic dim_ok(input logic [11:0] dim);
        return (dim != 12'd0) && (dim <= MAX_FRAME_DIM);
    endfunction

    // Operands are widened first so the product keeps its low 11 bits.
    function automatic logic [10:0] mb_total(input logic [6:0] w, input logic [6:0] h);
        return 11'({4'b0, w} * {4'b0, h});
    endfunction

endpackage

// File: rtl/intra_mb_scheduler_if.sv
// Fetch-unit and intra-core handshakes seen by the MB scheduler.
// master = scheduler side, slave = fetch unit / intra core / CAVLC side.
interface intra_mb_scheduler_if #(
    parameter int MBW = 6
);
    logic           fetch_req;
    logic [MBW-1:0] fetch_mb_x;
    logic [MBW-1:0] fetch_mb_y;
    logic           fetch_ack;
    logic           fetch_valid_o;
    logic           intra_ready;
    logic           dctq_valid;
    logic           cavlc_cnt_ready;

    modport master (
        output fetch_req, fetch_mb_x, fetch_mb_y, fetch_valid_o,
        input  fetch_ack, intra_ready, dctq_valid, cavlc_cnt_ready
    );

    modport slave (
        input  fetch_req, fetch_mb_x, fetch_mb_y, fetch_valid_o,
        output fetch_ack, intra_ready, dctq_valid, cavlc_cnt_ready
    );
endinterface

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock coordinate counter for one frame.
// Clears to (0,0) and advances x first, wrapping into y at mb_w.
module mb_raster_counter #(
    parameter int MBW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    input  logic [MBW:0]   mb_w,
    input  logic [MBW:0]   mb_h,
    output logic [MBW-1:0] mb_x,
    output logic [MBW-1:0] mb_y,
    output logic           last
);
    localparam int W = MBW + 1;

    logic [MBW-1:0] mb_x_q, mb_x_d;
    logic [MBW-1:0] mb_y_q, mb_y_d;
    logic [W-1:0]   x_inc;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mb_x_d = mb_x_q;
        mb_y_d = mb_y_q;
        x_inc  = {1'b0, mb_x_q} + W'(1);
        if (clr) begin
            mb_x_d = '0;
            mb_y_d = '0;
        end else if (adv) begin
            if (x_inc == mb_w) begin
                mb_x_d = '0;
                mb_y_d = mb_y_q + MBW'(1);
            end else begin
                mb_x_d = x_inc[MBW-1:0];
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb_x_q <= '0;
            mb_y_q <= '0;
        end else begin
            mb_x_q <= mb_x_d;
            mb_y_q <= mb_y_d;
        end
    end

    assign mb_x = mb_x_q;
    assign mb_y = mb_y_q;
    assign last = ({1'b0, mb_x_q} == mb_w - W'(1)) && ({1'b0, mb_y_q} == mb_h - W'(1));

endmodule

// File: rtl/intra_mb_scheduler.sv
// Frame-level sequencer for the luma intra 4x4 path: fetches MBs in raster
// order, issues them to the intra core and retires them by counting 4x4 blocks.
module intra_mb_scheduler
    import h264_pkg::*;
#(
    parameter int BLK_PER_MB = h264_pkg::BLK_PER_MB,
    parameter int MBW        = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] frame_width,
    input  logic [11:0] frame_height,
    output logic        h264_reset,
    output logic        busy,
    output logic        mb_done,
    output logic        frame_done,
    intra_mb_scheduler_if.master bus
);
    localparam int         W        = MBW + 1;
    localparam logic [3:0] BLK_LAST = 4'(BLK_PER_MB - 1);

    sched_state_e state_q, state_d;

    logic [W-1:0]   mb_w_q, mb_w_d;
    logic [W-1:0]   mb_h_q, mb_h_d;
    logic [10:0]    total_q, total_d;
    logic [3:0]     blk_cnt_q, blk_cnt_d;
    logic [10:0]    mb_retired_q, mb_retired_d;

    logic h264_reset_q, h264_reset_d;
    logic fetch_req_q, fetch_req_d;
    logic fetch_valid_q, fetch_valid_d;
    logic busy_q, busy_d;
    logic mb_done_q, mb_done_d;
    logic frame_done_q, frame_done_d;

    logic           start_ok;
    logic           blk_hs;
    logic           rc_clr, rc_adv, rc_last;
    logic [MBW-1:0] rc_x, rc_y;

    mb_raster_counter #(.MBW(MBW)) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (rc_clr),
        .adv  (rc_adv),
        .mb_w (mb_w_q),
        .mb_h (mb_h_q),
        .mb_x (rc_x),
        .mb_y (rc_y),
        .last (rc_last)
    );

    assign start_ok = start && dim_ok(frame_width) && dim_ok(frame_height);

    always_comb begin
        state_d = state_q;
        mb_w_d  = mb_w_q;
        mb_h_d  = mb_h_q;
        total_d = total_q;
        rc_clr  = 1'b0;
        rc_adv  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mb_w_d  = W'(mbs_for_dim(frame_width));
                    mb_h_d  = W'(mbs_for_dim(frame_height));
                    total_d = mb_total(mbs_for_dim(frame_width), mbs_for_dim(frame_height));
                    state_d = INIT;
                end
            end
            INIT: begin
                rc_clr  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                if (fetch_req_q && bus.fetch_ack) state_d = ISSUE;
            end
            ISSUE: begin
                // The next fetch overlaps intra processing of the MB just accepted.
                if (fetch_valid_q && bus.intra_ready) begin
                    if (rc_last) begin
                        state_d = DRAIN;
                    end else begin
                        rc_adv  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (mb_retired_q == total_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the state being entered.
        h264_reset_d  = (state_d == INIT);
        fetch_req_d   = (state_d == FETCH);
        fetch_valid_d = (state_d == ISSUE);
        busy_d        = (state_d != IDLE);
        frame_done_d  = (state_d == DONE);
    end

    // Retirement runs independently of the FSM; handshakes outside a frame are dropped.
    assign blk_hs = busy_q && bus.dctq_valid && bus.cavlc_cnt_ready;

    always_comb begin
        blk_cnt_d    = blk_cnt_q;
        mb_retired_d = mb_retired_q;
        mb_done_d    = 1'b0;
        if (state_q == INIT) begin
            blk_cnt_d    = '0;
            mb_retired_d = '0;
        end else if (blk_hs) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d    = '0;
                mb_retired_d = mb_retired_q + 11'd1;
                mb_done_d    = 1'b1;
            end else begin
                blk_cnt_d = blk_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mb_w_q        <= '0;
            mb_h_q        <= '0;
            total_q       <= '0;
            blk_cnt_q     <= '0;
            mb_retired_q  <= '0;
            h264_reset_q  <= 1'b0;
            fetch_req_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            mb_done_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mb_w_q        <= mb_w_d;
            mb_h_q        <= mb_h_d;
            total_q       <= total_d;
            blk_cnt_q     <= blk_cnt_d;
            mb_retired_q  <= mb_retired_d;
            h264_reset_q  <= h264_reset_d;
            fetch_req_q   <= fetch_req_d;
            fetch_valid_q <= fetch_valid_d;
            busy_q        <= busy_d;
            mb_done_q     <= mb_done_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign h264_reset        = h264_reset_q;
    assign busy              = busy_q;
    assign mb_done           = mb_done_q;
    assign frame_done        = frame_done_q;
    assign bus.fetch_req     = fetch_req_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.fetch_mb_x    = rc_x;
    assign bus.fetch_mb_y    = rc_y;

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Directed self-checking bench for intra_mb_scheduler: a small fetch/intra/CAVLC
// responder drives the handshakes while each step checks hand-computed results.
module tb_intra_mb_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic        h264_reset;
    logic        busy;
    logic        mb_done;
    logic        frame_done;

    intra_mb_scheduler_if #(.MBW(6)) bus ();

    intra_mb_scheduler #(.BLK_PER_MB(16), .MBW(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .h264_reset   (h264_reset),
        .busy         (busy),
        .mb_done      (mb_done),
        .frame_done   (frame_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int log_x[$];
    int log_y[$];
    int n_mb_done, n_frame_done, n_h264, n_overlap, n_unstable;
    int max_req_run, max_val_run, last_mb_cyc, frame_cyc;
    bit done_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int log_at(input bit want_x, input int idx);
        if (idx >= log_x.size()) return -1;
        return want_x ? log_x[idx] : log_y[idx];
    endfunction

    task automatic check_log(input string name, input int idx, input int ex, input int ey);
        check($sformatf("%s/fetch%0d_x", name, idx), log_at(1'b1, idx), ex);
        check($sformatf("%s/fetch%0d_y", name, idx), log_at(1'b0, idx), ey);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "/h264_reset"}, h264_reset, 0);
        check({name, "/busy"}, busy, 0);
        check({name, "/mb_done"}, mb_done, 0);
        check({name, "/frame_done"}, frame_done, 0);
        check({name, "/fetch_req"}, bus.fetch_req, 0);
        check({name, "/fetch_valid_o"}, bus.fetch_valid_o, 0);
        check({name, "/fetch_mb_x"}, bus.fetch_mb_x, 0);
        check({name, "/fetch_mb_y"}, bus.fetch_mb_y, 0);
    endtask

    // Start at cycle t: h264_reset is expected at t+1 and fetch_req of (0,0) at t+2.
    task automatic start_frame(input string name, input int w, input int h);
        frame_width         = 12'(w);
        frame_height        = 12'(h);
        bus.fetch_ack       = 1'b0;
        bus.intra_ready     = 1'b1;
        bus.dctq_valid      = 1'b0;
        bus.cavlc_cnt_ready = 1'b1;
        start               = 1'b1;
        tick();
        start = 1'b0;
        check({name, "/h264_reset_t1"}, h264_reset, 1);
        check({name, "/fetch_req_t1"}, bus.fetch_req, 0);
        tick();
        check({name, "/h264_reset_t2"}, h264_reset, 0);
        check({name, "/fetch_req_t2"}, bus.fetch_req, 1);
        check({name, "/first_xy"}, {bus.fetch_mb_x, bus.fetch_mb_y}, 0);
    endtask

    // Responder: acks a request once it has been up for more than ack_delay cycles,
    // holds intra_ready low for the first ready_hold cycles of the first offer, and
    // returns 16 coefficient blocks per accepted MB.
    task automatic model_run(input int max_cycles, input int ack_delay,
                             input int ready_hold, input int start_cycle);
        int         req_run, val_run, blocks_left, post;
        bit         prev_req, prev_val, first_issue;
        logic [5:0] px, py;
        log_x.delete();
        log_y.delete();
        n_mb_done = 0; n_frame_done = 0; n_h264 = 0; n_overlap = 0; n_unstable = 0;
        max_req_run = 0; max_val_run = 0; last_mb_cyc = -1; frame_cyc = -1;
        done_seen = 1'b0;
        req_run = 0; val_run = 0; blocks_left = 0; post = 0;
        prev_req = 1'b0; prev_val = 1'b0; first_issue = 1'b1;
        px = '0; py = '0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (post >= 3) break;
            if (bus.fetch_req && bus.fetch_valid_o) n_overlap++;
            if ((bus.fetch_req && prev_req) || (bus.fetch_valid_o && prev_val))
                if (bus.fetch_mb_x !== px || bus.fetch_mb_y !== py) n_unstable++;
            prev_req = bus.fetch_req;
            prev_val = bus.fetch_valid_o;
            px = bus.fetch_mb_x;
            py = bus.fetch_mb_y;
            req_run = bus.fetch_req ? req_run + 1 : 0;
            val_run = bus.fetch_valid_o ? val_run + 1 : 0;
            if (req_run > max_req_run) max_req_run = req_run;
            if (val_run > max_val_run) max_val_run = val_run;
            if (h264_reset) n_h264++;
            if (mb_done) begin
                n_mb_done++;
                last_mb_cyc = cyc;
            end
            if (frame_done) begin
                n_frame_done++;
                frame_cyc = cyc;
                done_seen = 1'b1;
            end

            start               = (cyc == start_cycle);
            bus.fetch_ack       = bus.fetch_req && (req_run > ack_delay);
            bus.intra_ready     = !(first_issue && bus.fetch_valid_o && val_run <= ready_hold);
            bus.dctq_valid      = (blocks_left > 0);
            bus.cavlc_cnt_ready = 1'b1;
            if (bus.fetch_req && bus.fetch_ack) begin
                log_x.push_back(int'(bus.fetch_mb_x));
                log_y.push_back(int'(bus.fetch_mb_y));
            end
            if (bus.fetch_valid_o && bus.intra_ready) begin
                blocks_left += 16;
                first_issue = 1'b0;
            end
            if (bus.dctq_valid) blocks_left--;
            if (done_seen) post++;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string name, input int n_mbs);
        check({name, "/completed"}, done_seen, 1);
        check({name, "/fetch_count"}, log_x.size(), n_mbs);
        check({name, "/mb_done_count"}, n_mb_done, n_mbs);
        check({name, "/frame_done_count"}, n_frame_done, 1);
        check({name, "/frame_after_mb"}, (frame_cyc > last_mb_cyc), 1);
        check({name, "/extra_h264_reset"}, n_h264, 0);
        check({name, "/req_valid_overlap"}, n_overlap, 0);
        check({name, "/coord_unstable"}, n_unstable, 0);
        check({name, "/busy_after"}, busy, 0);
    endtask

    initial begin
        rst                 = 1'b0;
        start               = 1'b0;
        frame_width         = '0;
        frame_height        = '0;
        bus.fetch_ack       = 1'b0;
        bus.intra_ready     = 1'b0;
        bus.dctq_valid      = 1'b0;
        bus.cavlc_cnt_ready = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();

        // 32x16: two MBs in one row.
        start_frame("f32x16", 32, 16);
        model_run(200, 0, 0, -1);
        check_frame("f32x16", 2);
        check_log("f32x16", 0, 0, 0);
        check_log("f32x16", 1, 1, 0);
        check("f32x16/req_len", max_req_run, 1);

        // 20x20 rounds up to a 2x2 MB frame.
        start_frame("f20x20", 20, 20);
        model_run(300, 0, 0, -1);
        check_frame("f20x20", 4);
        check_log("f20x20", 0, 0, 0);
        check_log("f20x20", 1, 1, 0);
        check_log("f20x20", 2, 0, 1);
        check_log("f20x20", 3, 1, 1);

        // Ack withheld for 5 cycles: request held 6 cycles in total.
        start_frame("ackdly", 16, 16);
        model_run(200, 5, 0, -1);
        check_frame("ackdly", 1);
        check("ackdly/req_len", max_req_run, 6);

        // intra_ready low for 20 cycles of the first offer.
        start_frame("rdyhold", 32, 16);
        model_run(300, 0, 20, -1);
        check_frame("rdyhold", 2);
        check("rdyhold/valid_len", max_val_run, 21);
        check_log("rdyhold", 1, 1, 0);

        // start while busy is dropped and never re-launches a frame.
        start_frame("busystart", 16, 16);
        model_run(200, 0, 10, 3);
        check_frame("busystart", 1);

        // Out-of-range dimensions are rejected in IDLE.
        frame_width  = 12'd0;
        frame_height = 12'd16;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("w0/h264_reset", h264_reset, 0);
        check("w0/busy", busy, 0);
        tick();
        check("w0/fetch_req", bus.fetch_req, 0);
        frame_width  = 12'd16;
        frame_height = 12'd1025;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("h1025/h264_reset", h264_reset, 0);
        check("h1025/busy", busy, 0);

        // 1024 wide: the full 64-MB row, last MB at x=63.
        start_frame("w1024", 1024, 16);
        model_run(1500, 0, 0, -1);
        check_frame("w1024", 64);
        check_log("w1024", 1, 1, 0);
        check_log("w1024", 63, 63, 0);

        // 64x64 aborted by reset while draining, then a fresh frame.
        start_frame("abort", 64, 64);
        model_run(60, 0, 0, -1);
        check("abort/fetch_count", log_x.size(), 16);
        check_log("abort", 15, 3, 3);
        check("abort/busy_drain", busy, 1);
        check("abort/no_frame_done", n_frame_done, 0);
        rst = 1'b0;
        #2;
        check_outputs_zero("abort_async");
        tick();
        tick();
        check("abort/frame_done_held", frame_done, 0);
        bus.dctq_valid = 1'b0;
        rst = 1'b1;
        tick();
        start_frame("restart", 16, 16);
        model_run(200, 0, 0, -1);
        check_frame("restart", 1);
        check_log("restart", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/intra_mb_scheduler.md
# intra_mb_scheduler

Frame-level sequencer for the luma intra 4x4 datapath. Walks macroblocks in raster order, requests each MB's 16x16 pixels from the fetch unit, hands the loaded MB to the intra core, and counts consumed 4x4 DCT/Q blocks to retire MBs. It also generates the per-frame `h264_reset` pulse and reports frame completion to the top-level controller.

## Interface
- `BLK_PER_MB`, 16: 4x4 luma blocks per MB; retire threshold.
- `MBW`, 6: width of the MB coordinate fields.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame start request.
- `frame_width`, `frame_height` in 12: pixel dimensions, sampled at start acceptance.
- `h264_reset` out 1: one-cycle pulse that clears the downstream neighbour and line buffers.
- `fetch_req` out 1: request an MB fetch.
- `fetch_mb_x`, `fetch_mb_y` out MBW: coordinates of the requested MB.
- `fetch_ack` in 1: MB pixels are valid at the intra core input.
- `fetch_valid_o` out 1: offer the fetched MB to the intra core.
- `intra_ready` in 1: intra core is idle and accepts an MB.
- `dctq_valid` in 1: intra core is presenting a 4x4 coefficient block.
- `cavlc_cnt_ready` in 1: CAVLC accepts the presented block.
- `busy` out 1: a frame is in progress.
- `mb_done` out 1: pulse when an MB's 16th block is consumed.
- `frame_done` out 1: pulse when the frame's last MB retires.

## Operation
- Start acceptance:
  - `start` is accepted only in IDLE.
  - `start` is ignored if either dimension is 0 or greater than 1024.
  - The scheduler latches `mb_w = (frame_width+15)>>4` and `mb_h = (frame_height+15)>>4`. Partial MBs round up.
  - `total = mb_w*mb_h`, 11 bits.
- FSM states:
  - IDLE → INIT on accepted `start`.
  - INIT → FETCH. `h264_reset=1` for exactly this cycle. All coordinates and counters clear.
  - FETCH: `fetch_req=1` with stable coordinates. FETCH → ISSUE on `fetch_req && fetch_ack`.
  - ISSUE: `fetch_valid_o=1`. On `fetch_valid_o && intra_ready`: if the issued MB is the last one, go to DRAIN; otherwise advance the coordinates and go to FETCH.
  - DRAIN → DONE when the retired count equals `total`.
  - DONE: `frame_done=1` for one cycle, then → IDLE.
- Coordinate advance: `mb_x+1`; if it reaches `mb_w`, wrap `mb_x` to 0 and increment `mb_y`. The last MB is (`mb_w-1`, `mb_h-1`).
- Prefetch: the next MB's fetch is issued while the intra core processes the current MB. ISSUE waits on `intra_ready`, so at most one MB is fetched but not yet accepted.
- Retire counter (independent of the FSM):
  - 4-bit `blk_cnt` increments on `dctq_valid && cavlc_cnt_ready` while `busy`.
  - On the 15→0 wrap, `mb_done` pulses and the 11-bit `mb_retired` increments.
  - Handshakes while not `busy` are ignored.
- `busy` is high in every state except IDLE.

## Timing
- Reset values (async, on `rst=0`): state IDLE; every output 0; `fetch_mb_x`/`fetch_mb_y` 0; all counters 0.
- Reset asserted mid-frame aborts immediately. No `frame_done` is produced.
- All outputs are registered.
- `start` at cycle t:
  - `h264_reset` high at t+1.
  - `fetch_req` high from t+2.
- `fetch_req` may be acked in the same cycle it rises. The next state takes effect on the following edge.
- A `start` arriving while `busy` is dropped, not queued.
- Simultaneous retire and issue of the last MB in the same cycle is legal. DRAIN evaluates the updated count on the next cycle.
- `fetch_valid_o` and `fetch_req` are never high together.
- `fetch_req` falls the cycle after ack; `fetch_valid_o` falls the cycle after acceptance.
- `mb_done` and `frame_done` are single-cycle pulses. `frame_done` follows the final `mb_done` by at least 1 cycle.

## Structure
- Shared package `h264_pkg` holds:
  - the state enum `sched_state_e` (IDLE, INIT, FETCH, ISSUE, DRAIN, DONE);
  - constants `MAX_FRAME_DIM=1024` and `BLK_PER_MB=16`.
- One sub-module, `mb_raster_counter`: holds `mb_x`/`mb_y`, takes `mb_w`/`mb_h`, has inputs `clr` and `adv`, and outputs `last`.
- The FSM and the retire counter stay in the top.

## Test plan
- 32x16 frame, immediate acks, `intra_ready=1`, `cavlc_cnt_ready=1`, 16 `dctq_valid` per MB → fetches (0,0),(1,0); two `mb_done` pulses; `frame_done` once; `busy` low afterwards.
- 20x20 frame → `mb_w=mb_h=2`; fetch order (0,0),(1,0),(0,1),(1,1); `frame_done` after the 4th retire.
- `fetch_ack` delayed 5 cycles → `fetch_req` and coordinates held stable for all 5 cycles; exactly one transfer.
- `intra_ready` low for 20 cycles during ISSUE → `fetch_valid_o` held, no coordinate advance, no second `fetch_req`.
- `start` while `busy`, and `start` with `frame_width=0` → both ignored; no `h264_reset` pulse.
- `rst` low during DRAIN of a 64x64 frame → all outputs 0 asynchronously; a new `start` then begins at (0,0).
